// File: rtl/trusted_vc_buffer_pkg.sv
// rtl/trusted_vc_buffer_pkg.sv - shared constants, flit type and width helper for trusted_vc_buffer
package trusted_vc_pkg;

    localparam int DEF_FLIT_W    = 128;
    localparam int DEF_NUM_VC    = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_TRUST_MIN = 8;

    // Routing header fields at the top of every flit
    localparam int HDR_FIELD_W = 3;
    localparam int DST_X_MSB   = DEF_FLIT_W - 1;
    localparam int DST_Y_MSB   = DEF_FLIT_W - 4;

    typedef logic [DEF_FLIT_W-1:0] flit_t;

    // Ceiling log2, never below 1 so a single-VC build still has a one-bit id
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/trusted_vc_buffer_rr_arbiter.sv
// rtl/trusted_vc_buffer_rr_arbiter.sv - combinational round-robin arbiter, pointer held by the parent
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        idx   = 0;
        // Search upward from the pointer, wrapping N-1 -> 0
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                idx_o      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/trusted_vc_buffer.sv
// rtl/trusted_vc_buffer.sv - trust-gated multi-VC input buffer with RR drain; TVB_CREDIT_EN adds credit_rtn
module trusted_vc_buffer
    import trusted_vc_pkg::*;
#(
    parameter int FLIT_W    = DEF_FLIT_W,
    parameter int NUM_VC    = DEF_NUM_VC,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TRUST_W   = 4,
    parameter int TRUST_MIN = DEF_TRUST_MIN,
    parameter int DROP_W    = 8,
    localparam int VC_W     = clog2(NUM_VC),
    localparam int CNT_W    = clog2(DEPTH + 1),
    localparam int PTR_W    = clog2(DEPTH)
) (
    input  logic                    clk1,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [FLIT_W-1:0]       in_flit,
    input  logic [TRUST_W-1:0]      trust_in,
    output logic                    wr_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FLIT_W-1:0]       out_flit,
    output logic [VC_W-1:0]         out_vc,
    output logic [NUM_VC*CNT_W-1:0] em_pl,
`ifdef TVB_CREDIT_EN
    output logic [NUM_VC-1:0]       credit_rtn,
`endif
    output logic [DROP_W-1:0]       drop_cnt
);

    logic [FLIT_W-1:0] mem_q [NUM_VC][DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
    logic [CNT_W-1:0]  occ_q    [NUM_VC];
    logic [CNT_W-1:0]  occ_d    [NUM_VC];

    logic [VC_W-1:0]   rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic [VC_W-1:0]   out_vc_q, out_vc_d;
    logic              wr_err_q, wr_err_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              trust_ok;
    logic              vc_in_range;
    logic              vc_full;
    logic              wr_ok;
    logic              load_slot;
    logic              rd_fire;
    logic [NUM_VC-1:0] req;
    logic [NUM_VC-1:0] gnt;
    logic [VC_W-1:0]   gnt_idx;

    always_comb begin
        trust_ok    = 32'(trust_in) >= 32'(TRUST_MIN);
        vc_in_range = 32'(wr_vc) < 32'(NUM_VC);
        vc_full     = vc_in_range ? (occ_q[wr_vc] == CNT_W'(DEPTH)) : 1'b0;
        wr_ok       = wr_en && trust_ok && vc_in_range && !vc_full;
        for (int v = 0; v < NUM_VC; v++) begin
            req[v] = occ_q[v] != '0;
        end
        load_slot = !out_valid_q || out_ready;
        rd_fire   = load_slot && (|req);
    end

    rr_arbiter #(
        .N     (NUM_VC),
        .IDX_W (VC_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (rr_q),
        .en_i  (load_slot),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_vc_d    = out_vc_q;
        rr_d        = rr_q;
        wr_err_d    = wr_en && trust_ok && (!vc_in_range || vc_full);
        drop_d      = drop_q;

        // A same-edge write and read on one VC cancel in the occupancy count
        for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            occ_d[v]    = occ_q[v];
            if (wr_ok && (32'(wr_vc) == 32'(v))) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
                if (!gnt[v]) begin
                    occ_d[v] = occ_q[v] + CNT_W'(1);
                end
            end
            if (gnt[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
                if (!(wr_ok && (32'(wr_vc) == 32'(v)))) begin
                    occ_d[v] = occ_q[v] - CNT_W'(1);
                end
            end
        end

        if (load_slot) begin
            out_valid_d = rd_fire;
            if (rd_fire) begin
                out_flit_d = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
                out_vc_d   = gnt_idx;
                rr_d       = (32'(gnt_idx) == 32'(NUM_VC - 1)) ? '0 : gnt_idx + VC_W'(1);
            end
        end

        if (wr_en && !trust_ok && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_vc_q    <= '0;
            rr_q        <= '0;
            wr_err_q    <= 1'b0;
            drop_q      <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                occ_q[v]    <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_vc_q    <= out_vc_d;
            rr_q        <= rr_d;
            wr_err_q    <= wr_err_d;
            drop_q      <= drop_d;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                occ_q[v]    <= occ_d[v];
            end
        end
    end

    // Payload storage is not reset; occupancy counters decide what is live
    always_ff @(posedge clk1) begin
        if (wr_ok) begin
            mem_q[wr_vc][wr_ptr_q[wr_vc]] <= in_flit;
        end
    end

    always_comb begin
        em_pl = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            em_pl[v*CNT_W +: CNT_W] = CNT_W'(DEPTH) - occ_q[v];
        end
    end

    assign wr_err    = wr_err_q;
    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_vc    = out_vc_q;
    assign drop_cnt  = drop_q;

`ifdef TVB_CREDIT_EN
    logic [NUM_VC-1:0] credit_q;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= gnt;
        end
    end

    assign credit_rtn = credit_q;
`endif

endmodule
